// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared constants and types for the PS/2 key event decoder.
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] LSHIFT       = 8'h12;
    localparam logic [7:0] RSHIFT       = 8'h59;

    localparam logic [7:0] IGN_NULL   = 8'h00;
    localparam logic [7:0] IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_ERR    = 8'hFF;

    // Pause is E1 followed by 7 more bytes; counter wraps back after the last one
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == IGN_NULL) || (b == IGN_BAT_OK) || (b == IGN_ACK) ||
               (b == IGN_RESEND) || (b == IGN_ERR);
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Key event stream (valid/ready) between the decoder and the ASCII mapper.
interface ps2_key_event_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_key_event_decoder_key_event_fifo.sv
// First-word fall-through event FIFO; head reads as zero while empty.
import ps2_pkg::*;

module key_event_fifo #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  key_evt_t       push_data,
    input  logic           pop,
    output key_evt_t       head,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty
);

    key_evt_t [DEPTH-1:0] mem;
    logic [AW-1:0]        wptr, rptr;
    logic                 do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push lands in
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code stream to key events with shift tracking and event FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the held key.
import ps2_pkg::*;

module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    ps2_byte,
    input  logic                          ps2_byte_valid,
    ps2_key_event_decoder_if.master       evt,
    output logic                          shift_held,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    dec_state_t state, state_nx;
    logic [2:0] pause_cnt, pause_cnt_nx;
    logic       emit;
    key_evt_t   emit_evt, head;
    logic       push, pop, full, empty;
    logic       shift_l, shift_r;

    always_comb begin
        state_nx     = state;
        pause_cnt_nx = pause_cnt;
        emit         = 1'b0;
        emit_evt     = '{ext: 1'b0, brk: 1'b0, code: ps2_byte};
        if (ps2_byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (ps2_byte == PREFIX_EXT)        state_nx = S_EXT;
                    else if (ps2_byte == PREFIX_BRK)   state_nx = S_BRK;
                    else if (ps2_byte == PREFIX_PAUSE) state_nx = S_PAUSE;
                    else if (!is_ignored(ps2_byte))    emit     = 1'b1;
                end
                S_EXT: begin
                    emit_evt.ext = 1'b1;
                    if (ps2_byte == PREFIX_BRK) state_nx = S_EXT_BRK;
                    else begin
                        // E0 12 is the fake shift some keyboards send around nav keys
                        emit     = (ps2_byte != LSHIFT);
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: begin
                    emit_evt.brk = 1'b1;
                    emit         = 1'b1;
                    state_nx     = S_IDLE;
                end
                S_EXT_BRK: begin
                    emit_evt.ext = 1'b1;
                    emit_evt.brk = 1'b1;
                    emit         = (ps2_byte != LSHIFT);
                    state_nx     = S_IDLE;
                end
                S_PAUSE: begin
                    if (pause_cnt == PAUSE_LAST) begin
                        pause_cnt_nx = '0;
                        state_nx     = S_IDLE;
                    end else begin
                        pause_cnt_nx = pause_cnt + 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pause_cnt <= '0;
        end else begin
            state     <= state_nx;
            pause_cnt <= pause_cnt_nx;
        end
    end

    // Shift state follows the decoded event even if the FIFO drops it
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (emit && !emit_evt.ext) begin
            if (emit_evt.code == LSHIFT) shift_l <= !emit_evt.brk;
            if (emit_evt.code == RSHIFT) shift_r <= !emit_evt.brk;
        end
    end
    assign shift_held = shift_l | shift_r;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_key;
    logic       held;
    logic       repeat_make;

    assign repeat_make = emit && !emit_evt.brk && held &&
                         ({emit_evt.ext, emit_evt.code} == last_key);
    assign push        = emit && !repeat_make;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_key <= '0;
            held     <= 1'b0;
        end else if (emit) begin
            if (!emit_evt.brk) begin
                last_key <= {emit_evt.ext, emit_evt.code};
                held     <= 1'b1;
            end else if ({emit_evt.ext, emit_evt.code} == last_key) begin
                held     <= 1'b0;
            end
        end
    end
`else
    assign push = emit;
`endif

    assign pop = evt.evt_ready && !empty;

    key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (emit_evt),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset)                      overflow <= 1'b0;
        else if (push && full && !pop)  overflow <= 1'b1;
    end

    assign evt.evt_valid = !empty;
    assign evt.evt_code  = head.code;
    assign evt.evt_ext   = head.ext;
    assign evt.evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench: directed vector table, typematic sequence, random vs. sequence-level model.
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       shift_held;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       overflow;

    ps2_key_event_decoder_if evt_if();

    ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .evt            (evt_if.master),
        .shift_held     (shift_held),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [7:0] b, input logic r);
        reset              = rst;
        ps2_byte_valid     = v;
        ps2_byte           = b;
        evt_if.evt_ready   = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] b;
        logic       r;
        logic       ev;
        logic [7:0] ec;
        logic       ex;
        logic       eb;
        logic       sh;
        int         cnt;
        logic       ov;
    } vec_t;

    function automatic vec_t mk(logic rst, logic v, logic [7:0] b, logic r, logic ev,
                                logic [7:0] ec, logic ex, logic eb, logic sh, int cnt, logic ov);
        vec_t t;
        t = '{rst, v, b, r, ev, ec, ex, eb, sh, cnt, ov};
        return t;
    endfunction

    // ---------------- sequence-level reference model ----------------
    logic [9:0] mq[$];
    logic [7:0] pend[$];
    logic       m_sl, m_sr, m_ov;
    logic [8:0] m_last;
    logic       m_held;

    function automatic logic ign(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic m_step(input logic rst, input logic v, input logic [7:0] b, input logic r);
        logic       pop, emit, ext, brk, pushit;
        logic [9:0] ev;
        if (rst) begin
            mq.delete(); pend.delete();
            m_sl = 0; m_sr = 0; m_ov = 0; m_last = '0; m_held = 0;
            return;
        end
        pop  = r && (mq.size() != 0);
        emit = 0;
        ev   = '0;
        if (v) begin
            if (pend.size() > 0 && pend[0] == 8'hE1) begin
                pend.push_back(b);
                if (pend.size() == 8) pend.delete();
            end else begin
                pend.push_back(b);
                if (!((pend.size() == 1 && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) ||
                      (pend.size() == 2 && pend[0] == 8'hE0 && b == 8'hF0))) begin
                    ext = (pend[0] == 8'hE0);
                    brk = (pend[0] == 8'hF0) || (pend.size() == 3);
                    if (pend.size() == 1) emit = !ign(b);
                    else                  emit = !(ext && b == 8'h12);
                    ev = {ext, brk, b};
                    pend.delete();
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (emit) begin
            if (!ev[9] && ev[7:0] == 8'h12) m_sl = !ev[8];
            if (!ev[9] && ev[7:0] == 8'h59) m_sr = !ev[8];
            pushit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!ev[8]) begin
                if (m_held && {ev[9], ev[7:0]} == m_last) pushit = 0;
                m_last = {ev[9], ev[7:0]};
                m_held = 1;
            end else if ({ev[9], ev[7:0]} == m_last) begin
                m_held = 0;
            end
`endif
            if (pushit) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else                   m_ov = 1;
            end
        end
    endtask

    initial begin
        vec_t       tbl[$];
        logic [7:0] typ_bytes[6];
        logic [9:0] typ_exp[$];
        logic [9:0] typ_got[$];
        string      nm;

        reset = 1; ps2_byte_valid = 0; ps2_byte = 0; evt_if.evt_ready = 0;

        // ---------- directed vector table ----------
        //             rst v  byte  r  ev code  ex eb sh cnt ov
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 1, 1, 8'h1C, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 1, 1, 8'h1C, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h75, 1, 1, 8'h75, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h75, 1, 1, 8'h75, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 1, 8'h12, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 1, 1, 8'h1C, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 1, 8'h12, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        // fill to overflow with the consumer stalled
        tbl.push_back(mk(0, 1, 8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h32, 0, 1, 8'h1C, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 8'h21, 0, 1, 8'h1C, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 8'h23, 0, 1, 8'h1C, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 8'h24, 0, 1, 8'h1C, 0, 0, 0, 4, 1));
        tbl.push_back(mk(0, 1, 8'h2B, 1, 1, 8'h32, 0, 0, 0, 4, 1));
        // Pause sequence then a normal make
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hE1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h1C, 1, 1, 8'h1C, 0, 0, 0, 1, 0));
        // reset in the middle of an E0 prefix
        tbl.push_back(mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h75, 0, 1, 8'h75, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].r);
            nm = $sformatf("vec%0d", i);
            chk({nm, ".valid"}, 32'(evt_if.evt_valid), 32'(tbl[i].ev));
            chk({nm, ".code"},  32'(evt_if.evt_code),  32'(tbl[i].ec));
            chk({nm, ".ext"},   32'(evt_if.evt_ext),   32'(tbl[i].ex));
            chk({nm, ".brk"},   32'(evt_if.evt_break), 32'(tbl[i].eb));
            chk({nm, ".shift"}, 32'(shift_held),       32'(tbl[i].sh));
            chk({nm, ".count"}, 32'(fifo_count),       32'(tbl[i].cnt));
            chk({nm, ".ovf"},   32'(overflow),         32'(tbl[i].ov));
        end

        // ---------- typematic repeat sequence ----------
        typ_bytes = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
        typ_exp = '{10'h01C, 10'h11C, 10'h01C};
`else
        typ_exp = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        drive(1, 0, 8'h00, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drive(0, 1, typ_bytes[i], 1);
            else       drive(0, 0, 8'h00, 1);
            if (evt_if.evt_valid)
                typ_got.push_back({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code});
        end
        chk("typematic.nevents", 32'(typ_got.size()), 32'(typ_exp.size()));
        for (int i = 0; i < typ_exp.size(); i++)
            chk($sformatf("typematic.evt%0d", i),
                (i < typ_got.size()) ? 32'(typ_got[i]) : 32'hFFFF_FFFF, 32'(typ_exp[i]));

        // ---------- randomized run against the model ----------
        drive(1, 0, 8'h00, 0);
        m_step(1, 0, 8'h00, 0);
        for (int c = 0; c < 1500; c++) begin
            logic       rst, v, r;
            logic [7:0] b;
            int         sel;
            rst = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 9) < 4);
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5, 6:    b = 8'h12;
                7:       b = 8'h59;
                8, 9:    b = 8'h1C;
                10:      b = 8'hAA;
                11:      b = 8'h00;
                default: b = 8'($urandom_range(0, 255));
            endcase
            m_step(rst, v, b, r);
            drive(rst, v, b, r);
            chk("rnd.valid", 32'(evt_if.evt_valid), 32'(mq.size() != 0));
            chk("rnd.head",  32'({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}),
                             (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            chk("rnd.count", 32'(fifo_count), 32'(mq.size()));
            chk("rnd.shift", 32'(shift_held), 32'(m_sl | m_sr));
            chk("rnd.ovf",   32'(overflow),   32'(m_ov));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
